instr_fetch: RTL and testbench

Instruction fetch stage of the RISC-V core, directly upstream of `control_unit`.
- Holds the program counter and fetches 32-bit instructions from instruction memory over a valid/ready request port and a valid response port.
- Presents one registered instruction at a time to decode; `id_opcode` drives `control_unit.op`.
- Redirects the PC on a taken branch and discards any in-flight or held instruction.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/instr_fetch_if.sv | 34 +++
 rtl/instr_fetch_pc_reg.sv | 24 ++
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core constants and fetch FSM state type
package riscv_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // addi x0,x0,0 presented to decode whenever no instruction is valid
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } fetchState_t;

    function automatic logic [6:0] opcodeOf(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch stage bus: imem request/response, decode handoff, branch redirect
interface instr_fetch_if;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        misalign;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output id_valid, id_instr, id_opcode, id_pc,
        input  id_ready, br_taken, br_target,
        output misalign
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  id_valid, id_instr, id_opcode, id_pc,
        output id_ready, br_taken, br_target,
        input  misalign
    );

endinterface

// File: rtl/instr_fetch_pc_reg.sv
// rtl/instr_fetch_pc_reg.sv - program counter with async reset, +4 increment and redirect mux
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] target,
    input  logic        inc,
    output logic [31:0] pc
);

    // Redirect has priority over sequential advance; wraps modulo 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage; INSTR_FETCH_MISALIGN_CHECK_EN enables misaligned branch-target rejection
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    import riscv_pkg::*;

    fetchState_t state, stateNext;
    logic [31:0] pc, pcTarget;
    logic        pcLoad, pcInc;
    logic        brAct, tgtOk;
    logic        idValid, idValidNext;
    logic [31:0] idInstr, idInstrNext;
    logic [31:0] idPc, idPcNext;
    logic        misalignQ, misalignNext;

    assign brAct = bus.br_taken && (state != S_IDLE);

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    assign tgtOk    = (bus.br_target[1:0] == 2'b00);
    assign pcTarget = bus.br_target;
`else
    logic unusedTgtBits;
    assign unusedTgtBits = ^bus.br_target[1:0];
    assign tgtOk         = 1'b1;
    assign pcTarget      = {bus.br_target[31:2], 2'b00};
`endif

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (pcLoad),
        .target (pcTarget),
        .inc    (pcInc),
        .pc     (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idValid   <= 1'b0;
            idInstr   <= NOP_INSTR;
            idPc      <= RESET_PC;
            misalignQ <= 1'b0;
        end else begin
            state     <= stateNext;
            idValid   <= idValidNext;
            idInstr   <= idInstrNext;
            idPc      <= idPcNext;
            misalignQ <= misalignNext;
        end
    end

    always_comb begin
        stateNext    = state;
        idValidNext  = idValid;
        idInstrNext  = idInstr;
        idPcNext     = idPc;
        pcLoad       = 1'b0;
        pcInc        = 1'b0;
        misalignNext = 1'b0;

        case (state)
            S_IDLE: stateNext = S_REQ;
            S_REQ: begin
                if (bus.imem_req_ready) stateNext = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    stateNext   = S_HOLD;
                    idValidNext = 1'b1;
                    idInstrNext = bus.imem_rsp_data;
                    idPcNext    = pc;
                    pcInc       = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.id_ready) begin
                    stateNext   = S_REQ;
                    idValidNext = 1'b0;
                    idInstrNext = NOP_INSTR;
                end
            end
            S_DRAIN: begin
                if (bus.imem_rsp_valid) stateNext = S_REQ;
            end
            default: stateNext = S_IDLE;
        endcase

        // A taken branch overrides everything above: flush, redirect, and
        // drain any request the memory has already accepted
        if (brAct) begin
            idValidNext  = 1'b0;
            idInstrNext  = NOP_INSTR;
            idPcNext     = idPc;
            pcInc        = 1'b0;
            pcLoad       = tgtOk;
            misalignNext = !tgtOk;
            case (state)
                S_REQ:   stateNext = bus.imem_req_ready ? S_DRAIN : S_REQ;
                S_WAIT:  stateNext = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
                S_HOLD:  stateNext = S_REQ;
                S_DRAIN: stateNext = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
                default: stateNext = S_REQ;
            endcase
        end
    end

    assign bus.imem_req_valid = (state == S_REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.id_valid       = idValid;
    assign bus.id_instr       = idInstr;
    assign bus.id_opcode      = opcodeOf(idInstr);
    assign bus.id_pc          = idPc;
    assign bus.misalign       = misalignQ;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed, table-driven and randomized checks of instr_fetch
module tb_instr_fetch;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] tgt;
        logic [31:0] data;
        logic        fromHold;
        logic [6:0]  op;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkResetValues(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        chk({tag, "_req_addr"},  bus.imem_req_addr, 32'h0);
        chk({tag, "_id_valid"},  32'(bus.id_valid), 32'd0);
        chk({tag, "_id_instr"},  bus.id_instr, NOP_INSTR);
        chk({tag, "_id_pc"},     bus.id_pc, 32'h0);
        chk({tag, "_misalign"},  32'(bus.misalign), 32'd0);
    endtask

    // Bounded wait for a request, accept it, return the given word next cycle
    task automatic fetchOne(input logic [31:0] data);
        int n = 0;
        while (!bus.imem_req_valid && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", 32'(bus.imem_req_valid), 32'd1);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        step();
        bus.imem_rsp_valid = 1'b0;
    endtask

    task automatic consume();
        bus.id_ready = 1'b1;
        step();
        bus.id_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cur;
        logic [31:0] expPc;
        logic [31:0] pendAddr;
        bit          pend;
        int          cnt;
        int          delivered;

        rst                = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.id_ready       = 1'b0;
        bus.br_taken       = 1'b0;
        bus.br_target      = 32'h0;

        vecs[0] = '{tgt: 32'h0000_0200, data: 32'h0000_0033, fromHold: 1'b0, op: OPC_R};
        vecs[1] = '{tgt: 32'h0000_1000, data: 32'h0040_0003, fromHold: 1'b1, op: OPC_LOAD};
        vecs[2] = '{tgt: 32'h8000_0010, data: 32'h0000_2023, fromHold: 1'b0, op: OPC_STORE};
        vecs[3] = '{tgt: 32'hFFFF_FFFC, data: 32'h0000_0063, fromHold: 1'b1, op: OPC_BRANCH};
        vecs[4] = '{tgt: 32'h0000_0040, data: 32'h0010_0093, fromHold: 1'b0, op: OPC_OP_IMM};

        step();
        step();
        chkResetValues("reset");

        // Release; a branch during IDLE must be ignored
        rst           = 1'b0;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_0200;
        step();
        bus.br_taken  = 1'b0;
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr",  bus.imem_req_addr, 32'h0);

        // Basic fetch, then decode stall for five cycles
        fetchOne(32'h0000_0033);
        chk("t1_id_valid",  32'(bus.id_valid), 32'd1);
        chk("t1_id_opcode", 32'(bus.id_opcode), 32'(OPC_R));
        chk("t1_id_pc",     bus.id_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_id_instr",  bus.id_instr, 32'h0000_0033);
            chk("stall_id_pc",     bus.id_pc, 32'h0);
            chk("stall_no_req",    32'(bus.imem_req_valid), 32'd0);
        end
        consume();
        chk("t1_next_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t1_next_req_addr",  bus.imem_req_addr, 32'h4);
        chk("t1_cleared_valid",  32'(bus.id_valid), 32'd0);
        chk("t1_cleared_instr",  bus.id_instr, NOP_INSTR);

        // Branch in the same cycle the request is accepted: DRAIN
        bus.imem_req_ready = 1'b1;
        bus.br_taken       = 1'b1;
        bus.br_target      = 32'h0000_0100;
        step();
        bus.imem_req_ready = 1'b0;
        bus.br_taken       = 1'b0;
        chk("drain_no_req",   32'(bus.imem_req_valid), 32'd0);
        chk("drain_id_valid", 32'(bus.id_valid), 32'd0);
        step();
        chk("drain_wait_no_req", 32'(bus.imem_req_valid), 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("drain_dropped",  32'(bus.id_valid), 32'd0);
        chk("drain_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("drain_req_addr", bus.imem_req_addr, 32'h0000_0100);
        fetchOne(32'h00A0_0093);
        chk("br_id_valid", 32'(bus.id_valid), 32'd1);
        chk("br_id_pc",    bus.id_pc, 32'h0000_0100);
        chk("br_id_instr", bus.id_instr, 32'h00A0_0093);
        consume();

        // Misaligned target from HOLD
        fetchOne(memWord(32'h0000_0104));
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_0102;
        step();
        bus.br_taken  = 1'b0;
        chk("mis_id_valid", 32'(bus.id_valid), 32'd0);
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        chk("mis_flag",     32'(bus.misalign), 32'd1);
        chk("mis_pc_kept",  bus.imem_req_addr, 32'h0000_0108);
        step();
        chk("mis_pulse_end", 32'(bus.misalign), 32'd0);
`else
        chk("mis_flag_tied", 32'(bus.misalign), 32'd0);
        chk("mis_aligned",   bus.imem_req_addr, 32'h0000_0100);
`endif

        // Reset asserted while WAITing; a late response must be ignored
        while (!bus.imem_req_valid) step();
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        #1 rst = 1'b1;
        #1 chkResetValues("midrst");
        step();
        rst                = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hFFFF_FFFF;
        step();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("rst_req_addr",  bus.imem_req_addr, 32'h0);
        chk("rst_late_idle", 32'(bus.id_valid), 32'd0);
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("rst_late_req",  32'(bus.id_valid), 32'd0);
        chk("rst_still_req", 32'(bus.imem_req_valid), 32'd1);
        fetchOne(32'h0000_0033);
        chk("rst_fetch_pc", bus.id_pc, 32'h0);
        consume();

        // Table-driven redirects
        cur = 32'h4;
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].fromHold) begin
                fetchOne(memWord(cur));
                bus.id_ready = 1'b1;
            end
            bus.br_taken  = 1'b1;
            bus.br_target = vecs[i].tgt;
            step();
            bus.br_taken  = 1'b0;
            bus.id_ready  = 1'b0;
            chk("vec_req_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("vec_req_addr",  bus.imem_req_addr, vecs[i].tgt);
            chk("vec_flushed",   32'(bus.id_valid), 32'd0);
            fetchOne(vecs[i].data);
            chk("vec_id_valid",  32'(bus.id_valid), 32'd1);
            chk("vec_id_pc",     bus.id_pc, vecs[i].tgt);
            chk("vec_id_instr",  bus.id_instr, vecs[i].data);
            chk("vec_id_opcode", 32'(bus.id_opcode), 32'(vecs[i].op));
            consume();
            chk("vec_next_addr", bus.imem_req_addr, vecs[i].tgt + 32'd4);
            cur = vecs[i].tgt + 32'd4;
        end

        // Randomized traffic against a program-order model
        expPc     = cur;
        pend      = 1'b0;
        cnt       = 0;
        pendAddr  = 32'h0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            bit          rdy, idr, br, rspNow, acc;
            logic [31:0] tgt;
            rdy = ($urandom % 4) != 0;
            idr = ($urandom % 3) != 0;
            br  = ($urandom % 20) == 0;
            tgt = $urandom;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            rspNow = pend && (cnt == 0);
            bus.imem_req_ready = rdy;
            bus.id_ready       = idr;
            bus.br_taken       = br;
            bus.br_target      = tgt;
            bus.imem_rsp_valid = rspNow;
            bus.imem_rsp_data  = rspNow ? memWord(pendAddr) : 32'h0;
            acc = bus.imem_req_valid && rdy;
            if (acc) chk("rnd_req_addr", bus.imem_req_addr, expPc);
            if (bus.id_valid && idr && !br) begin
                chk("rnd_id_pc",    bus.id_pc, expPc);
                chk("rnd_id_instr", bus.id_instr, memWord(expPc));
                expPc = expPc + 32'd4;
                delivered++;
            end
            if (rspNow) pend = 1'b0;
            else if (pend) cnt--;
            if (acc) begin
                pend     = 1'b1;
                cnt      = $urandom % 3;
                pendAddr = expPc;
            end
            if (br) expPc = {tgt[31:2], 2'b00};
            step();
        end
        bus.imem_req_ready = 1'b0;
        bus.id_ready       = 1'b0;
        bus.br_taken       = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        chk("rnd_progress", 32'(delivered >= 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
